// File: rtl/disp_bin2bcd.sv
// Sequential 16-bit binary to 5-digit BCD converter (double-dabble, one bit per cycle)
// feeding the seven-segment multiplexer; freezes on a configurable terminal value.
module disp_bin2bcd #(
  parameter logic [15:0] STOP_VALUE = 16'd6765,
  parameter bit          STOP_EN    = 1'b1
) (
  input  logic        clk_100mhz,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic [19:0] bcd_out,
  output logic        bcd_valid,
  output logic        overflow,
  output logic        stopped
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_r;
  logic [19:0] bcd_acc_r;
  logic [15:0] bin_r;
  logic [3:0]  cnt_r;
  logic [15:0] cap_r;
  logic [35:0] work_s;

  // Adds 3 to every BCD nibble that is 5 or more, independently per nibble.
  function automatic logic [19:0] add3_nibbles(input logic [19:0] acc);
    logic [19:0] res;
    res = acc;
    for (int i = 0; i < 5; i++) begin
      if (acc[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
      end else begin
        res[i*4 +: 4] = acc[i*4 +: 4];
      end
    end
    return res;
  endfunction

  // Handshake is open only while idle and not frozen.
  assign in_ready = (state_r == IDLE) && !stopped;

  // One double-dabble iteration: adjust nibbles, then shift the whole register left.
  always_comb begin
    work_s = {add3_nibbles(bcd_acc_r), bin_r};
    work_s = {work_s[34:0], 1'b0};
  end

  // Conversion FSM and registered result outputs.
  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      bcd_acc_r <= 20'd0;
      bin_r     <= 16'd0;
      cnt_r     <= 4'd0;
      cap_r     <= 16'd0;
      bcd_out   <= 20'd0;
      bcd_valid <= 1'b0;
      overflow  <= 1'b0;
      stopped   <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            bcd_acc_r <= 20'd0;
            bin_r     <= in_data;
            cnt_r     <= 4'd0;
            cap_r     <= in_data;
            state_r   <= SHIFT;
          end else begin
            state_r   <= IDLE;
          end
        end
        SHIFT: begin
          bcd_acc_r <= work_s[35:16];
          bin_r     <= work_s[15:0];
          cnt_r     <= cnt_r + 4'd1;
          if (cnt_r == 4'd15) begin
            state_r <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          bcd_out   <= bcd_acc_r;
          bcd_valid <= 1'b1;
          overflow  <= (bcd_acc_r[19:16] != 4'd0);
          if (STOP_EN && (cap_r == STOP_VALUE)) begin
            stopped <= 1'b1;
          end else begin
            stopped <= stopped;
          end
          state_r   <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_bin2bcd.sv
// Directed, table-driven bench for disp_bin2bcd: one instance with the freeze enabled,
// one with it disabled.
module tb_disp_bin2bcd;

  logic        clk_100mhz = 1'b0;
  logic        reset      = 1'b1;
  logic        in_valid   = 1'b0;
  logic        in_valid2  = 1'b0;
  logic [15:0] in_data    = 16'd0;

  logic        in_ready,  bcd_valid,  overflow,  stopped;
  logic        in_ready2, bcd_valid2, overflow2, stopped2;
  logic [19:0] bcd_out, bcd_out2;

  int errors = 0;
  int checks = 0;

  always #5 clk_100mhz = ~clk_100mhz;

  disp_bin2bcd dut (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .bcd_out    (bcd_out),
    .bcd_valid  (bcd_valid),
    .overflow   (overflow),
    .stopped    (stopped)
  );

  disp_bin2bcd #(.STOP_EN(1'b0)) dut_nostop (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .in_valid   (in_valid2),
    .in_data    (in_data),
    .in_ready   (in_ready2),
    .bcd_out    (bcd_out2),
    .bcd_valid  (bcd_valid2),
    .overflow   (overflow2),
    .stopped    (stopped2)
  );

  typedef struct {
    logic [15:0] din;
    logic [19:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transfer one value into the selected instance and check latency and results.
  task automatic convert(input int sel, input logic [15:0] d, input logic [19:0] exp_bcd,
                         input logic exp_ovf, input logic exp_stop, input string name);
    int  n;
    bit  seen;
    seen = 1'b0;
    n    = 0;
    @(negedge clk_100mhz);
    in_data = d;
    if (sel == 0) in_valid = 1'b1; else in_valid2 = 1'b1;
    @(posedge clk_100mhz);
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk_100mhz);
      in_valid  = 1'b0;
      in_valid2 = 1'b0;
      in_data   = 16'hdead;
      @(posedge clk_100mhz);
      #1;
      if (i == 1) check({name, " ready_busy"}, (sel == 0) ? in_ready : in_ready2, 1'b0);
      if (((sel == 0) ? bcd_valid : bcd_valid2) === 1'b1) begin
        seen = 1'b1;
        n    = i;
      end
    end
    check({name, " latency"}, n, 17);
    check({name, " bcd"},  (sel == 0) ? bcd_out  : bcd_out2,  exp_bcd);
    check({name, " ovf"},  (sel == 0) ? overflow : overflow2, exp_ovf);
    check({name, " stop"}, (sel == 0) ? stopped  : stopped2,  exp_stop);
    @(posedge clk_100mhz);
    #1;
    check({name, " pulse_end"}, (sel == 0) ? bcd_valid : bcd_valid2, 1'b0);
  endtask

  initial begin
    int vcount;
    vecs[0] = '{16'd0,     20'h00000, 1'b0};
    vecs[1] = '{16'd9999,  20'h09999, 1'b0};
    vecs[2] = '{16'd65535, 20'h65535, 1'b1};
    vecs[3] = '{16'd10000, 20'h10000, 1'b1};
    vecs[4] = '{16'd1,     20'h00001, 1'b0};
    vecs[5] = '{16'd59999, 20'h59999, 1'b1};
    vecs[6] = '{16'd100,   20'h00100, 1'b0};
    vecs[7] = '{16'd12345, 20'h12345, 1'b1};
    vecs[8] = '{16'd5,     20'h00005, 1'b0};
    vecs[9] = '{16'd9,     20'h00009, 1'b0};

    // Reset state
    #1;
    check("rst_ready", in_ready, 1'b1);
    check("rst_bcd", bcd_out, 20'h0);
    check("rst_valid", bcd_valid, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_stop", stopped, 1'b0);
    repeat (3) @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    reset = 1'b0;

    foreach (vecs[k]) begin
      convert(0, vecs[k].din, vecs[k].bcd, vecs[k].ovf, 1'b0, $sformatf("vec%0d", k));
    end

    // 1597 with a dropped strobe of 42 mid-shift, then 2584 back-to-back at E18
    vcount = 0;
    @(negedge clk_100mhz);
    in_valid = 1'b1;
    in_data  = 16'd1597;
    @(posedge clk_100mhz);
    for (int e = 1; e <= 35; e++) begin
      @(negedge clk_100mhz);
      in_valid = (e == 5) || (e == 18);
      in_data  = (e == 5) ? 16'd42 : ((e == 18) ? 16'd2584 : 16'h0bad);
      @(posedge clk_100mhz);
      #1;
      if (bcd_valid) vcount++;
      if (e == 17) begin
        check("b2b_first_valid", bcd_valid, 1'b1);
        check("b2b_first_bcd", bcd_out, 20'h01597);
      end
      if (e == 35) begin
        check("b2b_second_valid", bcd_valid, 1'b1);
        check("b2b_second_bcd", bcd_out, 20'h02584);
      end
    end
    check("b2b_pulse_count", vcount, 2);
    @(negedge clk_100mhz);
    in_valid = 1'b0;

    // Reset at E8 of a 4181 conversion
    @(negedge clk_100mhz);
    in_valid = 1'b1;
    in_data  = 16'd4181;
    @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    in_valid = 1'b0;
    repeat (7) @(posedge clk_100mhz);
    #1;
    reset = 1'b1;
    #1;
    check("abort_bcd", bcd_out, 20'h0);
    check("abort_ready", in_ready, 1'b1);
    check("abort_valid", bcd_valid, 1'b0);
    @(negedge clk_100mhz);
    reset  = 1'b0;
    vcount = 0;
    repeat (25) begin
      @(posedge clk_100mhz);
      #1;
      if (bcd_valid) vcount++;
    end
    check("abort_no_valid", vcount, 0);
    convert(0, 16'd4181, 20'h04181, 1'b0, 1'b0, "after_abort");

    // Freeze disabled instance
    convert(1, 16'd6765, 20'h06765, 1'b0, 1'b0, "nostop_6765");
    convert(1, 16'd100,  20'h00100, 1'b0, 1'b0, "nostop_100");

    // Terminal value freezes the display
    convert(0, 16'd6765, 20'h06765, 1'b0, 1'b1, "stop_6765");
    #1;
    check("stop_ready", in_ready, 1'b0);
    @(negedge clk_100mhz);
    in_valid = 1'b1;
    in_data  = 16'd1234;
    @(negedge clk_100mhz);
    in_valid = 1'b0;
    vcount   = 0;
    repeat (30) begin
      @(posedge clk_100mhz);
      #1;
      if (bcd_valid) vcount++;
    end
    check("frozen_no_valid", vcount, 0);
    check("frozen_bcd", bcd_out, 20'h06765);
    check("frozen_stop", stopped, 1'b1);
    check("frozen_ovf", overflow, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
